// File: rtl/bus_arbiter2_if.sv
// Bus bundle between the two requesters, the arbiter and the shared slave port.
// The arbiter uses the "master" view because it drives the slave bus.
// The "slave" view is the environment side: requesters and the slave.
interface bus_arbiter2_if;
  localparam int unsigned DATA_W = 32;

  // requester side
  logic              m0_req_i;
  logic              m1_req_i;
  logic              m0_we_i;
  logic              m1_we_i;
  logic [DATA_W-1:0] m0_addr_i;
  logic [DATA_W-1:0] m1_addr_i;
  logic [DATA_W-1:0] m0_wdata_i;
  logic [DATA_W-1:0] m1_wdata_i;
  logic [DATA_W-1:0] m0_rdata_o;
  logic [DATA_W-1:0] m1_rdata_o;
  logic              m0_ack_o;
  logic              m1_ack_o;
  logic              m0_err_o;
  logic              m1_err_o;

  // slave side
  logic              s_rd_en_o;
  logic              s_wr_en_o;
  logic [DATA_W-1:0] s_addr_o;
  logic [DATA_W-1:0] s_data_o;
  logic [DATA_W-1:0] s_data_i;
  logic              s_ack_i;

  modport master (
    input  m0_req_i, m1_req_i, m0_we_i, m1_we_i,
    input  m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i,
    output m0_rdata_o, m1_rdata_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o,
    output s_rd_en_o, s_wr_en_o, s_addr_o, s_data_o,
    input  s_data_i, s_ack_i
  );

  modport slave (
    output m0_req_i, m1_req_i, m0_we_i, m1_we_i,
    output m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i,
    input  m0_rdata_o, m1_rdata_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o,
    input  s_rd_en_o, s_wr_en_o, s_addr_o, s_data_o,
    output s_data_i, s_ack_i
  );
endinterface

// File: rtl/bus_arbiter2.sv
// Two-master, one-slave round-robin bus arbiter with bounded ack timeout.
// One transaction in flight; all outputs registered.
module bus_arbiter2 #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              rst_n,
  bus_arbiter2_if.master    bus
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_last_grant, w_last_grant_nxt;
  logic                r_owner, w_owner_nxt;
  logic                r_we, w_we_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_rd_en, w_rd_en_nxt;
  logic                r_wr_en, w_wr_en_nxt;
  logic [DATA_W-1:0]   r_s_addr, w_s_addr_nxt;
  logic [DATA_W-1:0]   r_s_data, w_s_data_nxt;
  logic                r_m0_ack, w_m0_ack_nxt;
  logic                r_m1_ack, w_m1_ack_nxt;
  logic                r_m0_err, w_m0_err_nxt;
  logic                r_m1_err, w_m1_err_nxt;
  logic [DATA_W-1:0]   r_m0_rdata, w_m0_rdata_nxt;
  logic [DATA_W-1:0]   r_m1_rdata, w_m1_rdata_nxt;

  logic                w_any_req;
  logic                w_m1_wins;
  logic [DATA_W-1:0]   w_done_rdata;
  logic                w_done_err;
  logic                w_done;

  // Winner selection: a lone requester wins, a tie goes to the master not granted last.
  always_comb begin
    w_any_req = bus.m0_req_i | bus.m1_req_i;
    w_m1_wins = bus.m1_req_i & (~bus.m0_req_i | ~r_last_grant);
  end

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_owner_nxt      = r_owner;
    w_we_nxt         = r_we;
    w_cnt_nxt        = r_cnt;
    w_rd_en_nxt      = 1'b0;
    w_wr_en_nxt      = 1'b0;
    w_s_addr_nxt     = r_s_addr;
    w_s_data_nxt     = r_s_data;
    w_m0_ack_nxt     = 1'b0;
    w_m1_ack_nxt     = 1'b0;
    w_m0_err_nxt     = 1'b0;
    w_m1_err_nxt     = 1'b0;
    w_m0_rdata_nxt   = r_m0_rdata;
    w_m1_rdata_nxt   = r_m1_rdata;
    w_done           = 1'b0;
    w_done_err       = 1'b0;
    w_done_rdata     = bus.s_data_i;

    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_owner_nxt      = w_m1_wins;
          w_last_grant_nxt = w_m1_wins;
          w_we_nxt         = w_m1_wins ? bus.m1_we_i    : bus.m0_we_i;
          w_s_addr_nxt     = w_m1_wins ? bus.m1_addr_i  : bus.m0_addr_i;
          w_s_data_nxt     = w_m1_wins ? bus.m1_wdata_i : bus.m0_wdata_i;
          w_rd_en_nxt      = ~w_we_nxt;
          w_wr_en_nxt      = w_we_nxt;
          w_cnt_nxt        = '0;
          w_state_nxt      = ACCESS;
        end
      end
      ACCESS, WAIT: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (bus.s_ack_i) begin
          w_done       = 1'b1;
          w_done_err   = 1'b0;
          w_done_rdata = bus.s_data_i;
        end else if (r_cnt == CNT_LAST) begin
          w_done       = 1'b1;
          w_done_err   = 1'b1;
          w_done_rdata = ERR_DATA;
        end
        if (w_done) begin
          w_state_nxt = DONE;
          if (r_owner) begin
            w_m1_ack_nxt = 1'b1;
            w_m1_err_nxt = w_done_err;
            if (!r_we) w_m1_rdata_nxt = w_done_rdata;
          end else begin
            w_m0_ack_nxt = 1'b1;
            w_m0_err_nxt = w_done_err;
            if (!r_we) w_m0_rdata_nxt = w_done_rdata;
          end
        end else begin
          w_state_nxt = WAIT;
        end
      end
      DONE: begin
        w_s_addr_nxt = '0;
        w_s_data_nxt = '0;
        w_state_nxt  = IDLE;
      end
      default: begin
        w_s_addr_nxt = '0;
        w_s_data_nxt = '0;
        w_state_nxt  = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_we         <= 1'b0;
      r_cnt        <= '0;
      r_rd_en      <= 1'b0;
      r_wr_en      <= 1'b0;
      r_s_addr     <= '0;
      r_s_data     <= '0;
      r_m0_ack     <= 1'b0;
      r_m1_ack     <= 1'b0;
      r_m0_err     <= 1'b0;
      r_m1_err     <= 1'b0;
      r_m0_rdata   <= '0;
      r_m1_rdata   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_owner      <= w_owner_nxt;
      r_we         <= w_we_nxt;
      r_cnt        <= w_cnt_nxt;
      r_rd_en      <= w_rd_en_nxt;
      r_wr_en      <= w_wr_en_nxt;
      r_s_addr     <= w_s_addr_nxt;
      r_s_data     <= w_s_data_nxt;
      r_m0_ack     <= w_m0_ack_nxt;
      r_m1_ack     <= w_m1_ack_nxt;
      r_m0_err     <= w_m0_err_nxt;
      r_m1_err     <= w_m1_err_nxt;
      r_m0_rdata   <= w_m0_rdata_nxt;
      r_m1_rdata   <= w_m1_rdata_nxt;
    end
  end

  assign bus.s_rd_en_o  = r_rd_en;
  assign bus.s_wr_en_o  = r_wr_en;
  assign bus.s_addr_o   = r_s_addr;
  assign bus.s_data_o   = r_s_data;
  assign bus.m0_ack_o   = r_m0_ack;
  assign bus.m1_ack_o   = r_m1_ack;
  assign bus.m0_err_o   = r_m0_err;
  assign bus.m1_err_o   = r_m1_err;
  assign bus.m0_rdata_o = r_m0_rdata;
  assign bus.m1_rdata_o = r_m1_rdata;
endmodule

// File: tb/tb_bus_arbiter2.sv
// Bench for bus_arbiter2: transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_bus_arbiter2;
  localparam int          T   = 16;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  bus_arbiter2_if bus ();

  bus_arbiter2 #(.TIMEOUT_CYCLES(T), .ERR_DATA(ERR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: age counts cycles since the grant (1 = strobe cycle),
  // fin is the age at which the completion pulse is shown.
  bit          m_valid = 1'b0;
  int          m_age, m_fin;
  bit          m_owner, m_we, m_last, m_err;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] m_rdata [2];

  task automatic model_step();
    if (!rst_n) begin
      m_valid = 1'b1; m_age = 0; m_fin = 0; m_last = 1'b1; m_err = 1'b0;
      m_rdata[0] = '0; m_rdata[1] = '0;
    end else if (m_valid) begin
      if (m_age > 0 && m_age == m_fin) begin
        m_age = 0; m_fin = 0;
      end else if (m_age == 0) begin
        if (bus.m0_req_i || bus.m1_req_i) begin
          m_owner = (bus.m0_req_i && bus.m1_req_i) ? !m_last : bus.m1_req_i;
          m_last  = m_owner;
          m_we    = m_owner ? bus.m1_we_i    : bus.m0_we_i;
          m_addr  = m_owner ? bus.m1_addr_i  : bus.m0_addr_i;
          m_wdata = m_owner ? bus.m1_wdata_i : bus.m0_wdata_i;
          m_age   = 1; m_fin = 0;
        end
      end else begin
        if (bus.s_ack_i) begin
          m_fin = m_age + 1; m_err = 1'b0;
          if (!m_we) m_rdata[m_owner] = bus.s_data_i;
        end else if (m_age == T) begin
          m_fin = m_age + 1; m_err = 1'b1;
          if (!m_we) m_rdata[m_owner] = ERR;
        end
        m_age++;
      end
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always begin
    @(posedge clk);
    #1;
    model_step();
    if (m_valid) begin
      automatic bit done = (m_age > 0) && (m_age == m_fin);
      chk("mdl_rd_en", 32'(bus.s_rd_en_o), 32'(m_age == 1 && !m_we));
      chk("mdl_wr_en", 32'(bus.s_wr_en_o), 32'(m_age == 1 && m_we));
      chk("mdl_s_addr", bus.s_addr_o, (m_age > 0) ? m_addr : 32'h0);
      chk("mdl_s_data", bus.s_data_o, (m_age > 0) ? m_wdata : 32'h0);
      chk("mdl_m0_ack", 32'(bus.m0_ack_o), 32'(done && !m_owner));
      chk("mdl_m1_ack", 32'(bus.m1_ack_o), 32'(done && m_owner));
      chk("mdl_m0_err", 32'(bus.m0_err_o), 32'(done && !m_owner && m_err));
      chk("mdl_m1_err", 32'(bus.m1_err_o), 32'(done && m_owner && m_err));
      chk("mdl_m0_rdata", bus.m0_rdata_o, m_rdata[0]);
      chk("mdl_m1_rdata", bus.m1_rdata_o, m_rdata[1]);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  int n_acks;
  int order [4];

  initial begin
    rst_n = 1'b0;
    bus.m0_req_i = 1'b1; bus.m0_we_i = 1'b1;
    bus.m0_addr_i = 32'h100; bus.m0_wdata_i = 32'hA0A0_0001;
    bus.m1_req_i = 1'b1; bus.m1_we_i = 1'b1;
    bus.m1_addr_i = 32'h200; bus.m1_wdata_i = 32'hB0B0_0002;
    bus.s_ack_i = 1'b0; bus.s_data_i = '0;

    // Reset held two cycles with both requests high.
    repeat (2) @(negedge clk);
    chk("rst_rd_en", 32'(bus.s_rd_en_o), 0);
    chk("rst_wr_en", 32'(bus.s_wr_en_o), 0);
    chk("rst_acks", {30'h0, bus.m1_ack_o, bus.m0_ack_o}, 0);
    chk("rst_errs", {30'h0, bus.m1_err_o, bus.m0_err_o}, 0);
    chk("rst_s_addr", bus.s_addr_o, 0);
    chk("rst_s_data", bus.s_data_o, 0);
    chk("rst_m0_rdata", bus.m0_rdata_o, 0);
    chk("rst_m1_rdata", bus.m1_rdata_o, 0);

    // Continuous writes from both masters, slave acks immediately.
    rst_n = 1'b1;
    bus.s_ack_i = 1'b1;
    @(negedge clk);
    chk("rr_first_wr_en", 32'(bus.s_wr_en_o), 1);
    chk("rr_first_addr", bus.s_addr_o, 32'h100);
    n_acks = 0;
    for (int c = 0; c < 30 && n_acks < 4; c++) begin
      @(negedge clk);
      if (bus.m0_ack_o) begin
        order[n_acks] = 0; n_acks++;
        bus.m0_wdata_i = bus.m0_wdata_i + 32'h10;
      end
      if (bus.m1_ack_o && n_acks < 4) begin
        order[n_acks] = 1; n_acks++;
        bus.m1_wdata_i = bus.m1_wdata_i + 32'h10;
      end
    end
    bus.m0_req_i = 1'b0; bus.m1_req_i = 1'b0; bus.s_ack_i = 1'b0;
    chk("rr_ack_count", n_acks, 4);
    chk("rr_grant0", order[0], 0);
    chk("rr_grant1", order[1], 1);
    chk("rr_grant2", order[2], 0);
    chk("rr_grant3", order[3], 1);
    chk("rr_m1_rdata_kept", bus.m1_rdata_o, 0);
    repeat (2) @(negedge clk);

    // m0 read, slave acks in the strobe cycle.
    bus.m0_req_i = 1'b1; bus.m0_we_i = 1'b0; bus.m0_addr_i = 32'h10;
    @(negedge clk);
    chk("rd_strobe_c1", 32'(bus.s_rd_en_o), 1);
    chk("rd_addr_c1", bus.s_addr_o, 32'h10);
    bus.s_ack_i = 1'b1; bus.s_data_i = 32'h12345678;
    @(negedge clk);
    chk("rd_strobe_c2", 32'(bus.s_rd_en_o), 0);
    chk("rd_ack_c2", 32'(bus.m0_ack_o), 1);
    chk("rd_err_c2", 32'(bus.m0_err_o), 0);
    chk("rd_rdata_c2", bus.m0_rdata_o, 32'h12345678);
    bus.m0_req_i = 1'b0; bus.s_ack_i = 1'b0; bus.s_data_i = '0;
    repeat (2) @(negedge clk);

    // m1 read that times out, followed by a late slave ack.
    bus.m1_req_i = 1'b1; bus.m1_we_i = 1'b0; bus.m1_addr_i = 32'h44;
    for (int c = 1; c <= T; c++) begin
      @(negedge clk);
      if (c == 1) chk("to_strobe_c1", 32'(bus.s_rd_en_o), 1);
      chk("to_no_early_ack", 32'(bus.m1_ack_o), 0);
    end
    @(negedge clk);
    chk("to_ack_c17", 32'(bus.m1_ack_o), 1);
    chk("to_err_c17", 32'(bus.m1_err_o), 1);
    chk("to_rdata_c17", bus.m1_rdata_o, ERR);
    bus.m1_req_i = 1'b0;
    @(negedge clk);
    bus.s_ack_i = 1'b1; bus.s_data_i = 32'h0BAD_0BAD;
    @(negedge clk);
    chk("late_ack_ignored", {30'h0, bus.m1_ack_o, bus.m0_ack_o}, 0);
    chk("late_ack_rdata", bus.m1_rdata_o, ERR);
    bus.s_ack_i = 1'b0; bus.s_data_i = '0;
    repeat (2) @(negedge clk);

    // m0 write, ack delayed three cycles after the strobe.
    bus.m0_req_i = 1'b1; bus.m0_we_i = 1'b1;
    bus.m0_addr_i = 32'h80; bus.m0_wdata_i = 32'h55;
    @(negedge clk);
    chk("dly_strobe_c1", 32'(bus.s_wr_en_o), 1);
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      chk("dly_no_restrobe", {30'h0, bus.s_wr_en_o, bus.s_rd_en_o}, 0);
      chk("dly_no_ack", 32'(bus.m0_ack_o), 0);
      chk("dly_hold_data", bus.s_data_o, 32'h55);
    end
    bus.s_ack_i = 1'b1;
    @(negedge clk);
    chk("dly_ack_c5", 32'(bus.m0_ack_o), 1);
    chk("dly_err_c5", 32'(bus.m0_err_o), 0);
    chk("dly_rdata_kept", bus.m0_rdata_o, 32'h12345678);
    bus.m0_req_i = 1'b0; bus.s_ack_i = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during WAIT, then a normal m0 read.
    bus.m1_req_i = 1'b1; bus.m1_we_i = 1'b0; bus.m1_addr_i = 32'h90;
    @(negedge clk);
    chk("rw_strobe_c1", 32'(bus.s_rd_en_o), 1);
    @(negedge clk);
    rst_n = 1'b0; bus.m1_req_i = 1'b0;
    @(negedge clk);
    chk("rw_no_ack", {30'h0, bus.m1_ack_o, bus.m0_ack_o}, 0);
    chk("rw_addr_zero", bus.s_addr_o, 0);
    chk("rw_m0_rdata_cleared", bus.m0_rdata_o, 0);
    rst_n = 1'b1;
    bus.m0_req_i = 1'b1; bus.m0_we_i = 1'b0; bus.m0_addr_i = 32'h20;
    @(negedge clk);
    chk("rw_m0_strobe", 32'(bus.s_rd_en_o), 1);
    chk("rw_m0_addr", bus.s_addr_o, 32'h20);
    bus.s_ack_i = 1'b1; bus.s_data_i = 32'hCAFE0001;
    @(negedge clk);
    chk("rw_m0_ack", 32'(bus.m0_ack_o), 1);
    chk("rw_m0_rdata", bus.m0_rdata_o, 32'hCAFE0001);
    bus.m0_req_i = 1'b0; bus.s_ack_i = 1'b0; bus.s_data_i = '0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
